ibex_dummy_instr_checker: RTL and testbench



---
 rtl/ibex_pkg.sv | 15 +
 rtl/ibex_dummy_instr_decode.sv | 31 +++
 rtl/ibex_dummy_instr_checker.sv | 115 +++++++++++
 tb/tb_ibex_dummy_instr_checker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared constants for dummy-instruction insertion and checking.
// The inserter and the checker both import this so their encodings agree.
package ibex_pkg;

  localparam int unsigned TIMEOUT_CNT_W = 5;

  localparam logic [6:0] DummyOpcode = 7'h33;

  // {funct7, funct3} pairs a dummy may carry
  localparam logic [9:0] DummyAdd = {7'h00, 3'b000};
  localparam logic [9:0] DummyMul = {7'h01, 3'b000};
  localparam logic [9:0] DummyDiv = {7'h01, 3'b100};
  localparam logic [9:0] DummyAnd = {7'h00, 3'b111};

endpackage

// File: rtl/ibex_dummy_instr_decode.sv
// Pure combinational legality check of a dummy instruction word.
// rs1/rs2 are free; opcode, rd and the funct pair are pinned.
import ibex_pkg::*;

module ibex_dummy_instr_decode (
  input  logic [31:0] instr_data_i,
  output logic        legal_o
);

  logic [9:0] fn;
  logic       fn_ok;
  logic       op_ok;

  assign fn    = {instr_data_i[31:25], instr_data_i[14:12]};
  assign op_ok = (instr_data_i[6:0] == DummyOpcode) &&
                 (instr_data_i[11:7] == 5'd0);

  always_comb begin
    fn_ok = 1'b0;
    unique case (fn)
      DummyAdd,
      DummyMul,
      DummyDiv,
      DummyAnd: fn_ok = 1'b1;
      default:  fn_ok = 1'b0;
    endcase
  end

  assign legal_o = op_ok & fn_ok;

endmodule

// File: rtl/ibex_dummy_instr_checker.sv
// Monitors fetch->ID transfers, separates dummies from real instructions,
// and raises sticky alerts on malformed, spurious or starved dummies.
import ibex_pkg::*;

module ibex_dummy_instr_checker #(
  parameter int unsigned GapCntW  = 6,
  parameter int unsigned StatCntW = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                dummy_instr_en_i,
  input  logic [2:0]          dummy_instr_mask_i,
  input  logic                instr_valid_i,
  input  logic                id_in_ready_i,
  input  logic                instr_is_dummy_i,
  input  logic [31:0]         instr_data_i,
  input  logic                clear_i,
  output logic                real_retire_o,
  output logic                dummy_retire_o,
  output logic                alert_malformed_o,
  output logic                alert_starve_o,
  output logic                alert_spurious_o,
  output logic [StatCntW-1:0] dummy_cnt_o
);

  logic xfer;
  logic dummy_xfer;
  logic real_xfer;
  logic legal;

  logic [TIMEOUT_CNT_W-1:0] bound;
  logic [GapCntW-1:0]       lim;
  logic [GapCntW-1:0]       gap_q;
  logic [GapCntW-1:0]       gap_d;
  logic [GapCntW-1:0]       gap_base;
  logic [GapCntW-1:0]       gap_inc;
  logic [StatCntW-1:0]      cnt_q;
  logic [StatCntW-1:0]      cnt_d;
  logic [StatCntW-1:0]      cnt_base;

  logic real_ret_q;
  logic dummy_ret_q;
  logic mal_q;
  logic starve_q;
  logic spur_q;
  logic mal_set;
  logic starve_set;
  logic spur_set;

  ibex_dummy_instr_decode u_decode (
    .instr_data_i (instr_data_i),
    .legal_o      (legal)
  );

  assign xfer       = instr_valid_i & id_in_ready_i;
  assign dummy_xfer = xfer & instr_is_dummy_i;
  assign real_xfer  = xfer & ~instr_is_dummy_i;

  // One extra slot of slack covers the inserter's registered threshold
  assign bound = {dummy_instr_mask_i, 2'b11};
  assign lim   = GapCntW'(bound) + GapCntW'(1);

  // Clear acts first, so a coincident xfer still lands on top of it
  assign gap_base = clear_i ? '0 : gap_q;
  assign gap_inc  = (&gap_base) ? gap_base : gap_base + GapCntW'(1);
  assign cnt_base = clear_i ? '0 : cnt_q;

  always_comb begin
    gap_d = gap_base;
    if (!dummy_instr_en_i || dummy_xfer) begin
      gap_d = '0;
    end else if (real_xfer) begin
      gap_d = gap_inc;
    end
  end

  always_comb begin
    cnt_d = cnt_base;
    if (dummy_xfer && !(&cnt_base)) begin
      cnt_d = cnt_base + StatCntW'(1);
    end
  end

  assign mal_set    = dummy_xfer & ~legal;
  assign spur_set   = dummy_xfer & ~dummy_instr_en_i;
  assign starve_set = real_xfer & dummy_instr_en_i & (gap_inc > lim);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      gap_q       <= '0;
      cnt_q       <= '0;
      real_ret_q  <= 1'b0;
      dummy_ret_q <= 1'b0;
      mal_q       <= 1'b0;
      starve_q    <= 1'b0;
      spur_q      <= 1'b0;
    end else begin
      gap_q       <= gap_d;
      cnt_q       <= cnt_d;
      real_ret_q  <= real_xfer;
      dummy_ret_q <= dummy_xfer;
      mal_q       <= (mal_q & ~clear_i) | mal_set;
      starve_q    <= (starve_q & ~clear_i) | starve_set;
      spur_q      <= (spur_q & ~clear_i) | spur_set;
    end
  end

  assign real_retire_o     = real_ret_q;
  assign dummy_retire_o    = dummy_ret_q;
  assign alert_malformed_o = mal_q;
  assign alert_starve_o    = starve_q;
  assign alert_spurious_o  = spur_q;
  assign dummy_cnt_o       = cnt_q;

endmodule

// File: tb/tb_ibex_dummy_instr_checker.sv
// Bench for ibex_dummy_instr_checker: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_ibex_dummy_instr_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [2:0]  mask;
  logic        valid;
  logic        ready;
  logic        is_dummy;
  logic [31:0] data;
  logic        clear;
  logic        real_ret;
  logic        dummy_ret;
  logic        a_mal;
  logic        a_starve;
  logic        a_spur;
  logic [15:0] cnt;

  int checks = 0;
  int failures = 0;

  int m_gap;
  int m_cnt;
  bit m_rr, m_dr, m_mal, m_st, m_sp;

  always #5 clk = ~clk;

  ibex_dummy_instr_checker #(
    .GapCntW  (6),
    .StatCntW (16)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .dummy_instr_en_i   (en),
    .dummy_instr_mask_i (mask),
    .instr_valid_i      (valid),
    .id_in_ready_i      (ready),
    .instr_is_dummy_i   (is_dummy),
    .instr_data_i       (data),
    .clear_i            (clear),
    .real_retire_o      (real_ret),
    .dummy_retire_o     (dummy_ret),
    .alert_malformed_o  (a_mal),
    .alert_starve_o     (a_starve),
    .alert_spurious_o   (a_spur),
    .dummy_cnt_o        (cnt)
  );

  typedef struct {
    logic        v;
    logic        rdy;
    logic        dm;
    logic [31:0] data;
    logic        en;
    logic        clr;
    logic        e_rr;
    logic        e_dr;
    logic        e_mal;
    logic        e_st;
    logic        e_sp;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[12];

  function automatic bit ref_legal(logic [31:0] w);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = w[31:25];
    f3 = w[14:12];
    if (w[6:0] != 7'h33 || w[11:7] != 5'd0) return 1'b0;
    return (f7 == 7'd0 && f3 == 3'd0) || (f7 == 7'd1 && f3 == 3'd0) ||
           (f7 == 7'd1 && f3 == 3'd4) || (f7 == 7'd0 && f3 == 3'd7);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_upd();
    bit x, d, rl;
    if (!rst_n) begin
      m_gap = 0; m_cnt = 0;
      m_rr = 0; m_dr = 0; m_mal = 0; m_st = 0; m_sp = 0;
      return;
    end
    x  = valid && ready;
    d  = x && is_dummy;
    rl = x && !is_dummy;
    m_rr = rl;
    m_dr = d;
    if (clear) begin
      m_mal = 0; m_st = 0; m_sp = 0; m_cnt = 0; m_gap = 0;
    end
    if (d && !ref_legal(data)) m_mal = 1;
    if (d && !en) m_sp = 1;
    if (d && m_cnt < 65535) m_cnt++;
    if (!en || d) m_gap = 0;
    else if (rl) begin
      if (m_gap < 63) m_gap++;
      if (m_gap > int'(mask) * 4 + 3 + 1) m_st = 1;
    end
  endtask

  task automatic cmp_model(string tag);
    chk({tag, "_real_retire"}, 32'(real_ret), 32'(m_rr));
    chk({tag, "_dummy_retire"}, 32'(dummy_ret), 32'(m_dr));
    chk({tag, "_malformed"}, 32'(a_mal), 32'(m_mal));
    chk({tag, "_starve"}, 32'(a_starve), 32'(m_st));
    chk({tag, "_spurious"}, 32'(a_spur), 32'(m_sp));
    chk({tag, "_cnt"}, 32'(cnt), 32'(m_cnt));
  endtask

  task automatic step(logic r, logic v, logic rd, logic dm,
                      logic [31:0] w, logic e, logic [2:0] mk,
                      logic c, bit do_cmp, string tag);
    @(negedge clk);
    rst_n = r; valid = v; ready = rd; is_dummy = dm;
    data = w; en = e; mask = mk; clear = c;
    @(posedge clk);
    model_upd();
    #1;
    if (do_cmp) cmp_model(tag);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    logic [9:0]  fns[4];
    logic [9:0]  f;
    fns[0] = 10'b0000000_000;
    fns[1] = 10'b0000001_000;
    fns[2] = 10'b0000001_100;
    fns[3] = 10'b0000000_111;
    w = $urandom;
    case ($urandom_range(0, 3))
      0, 1: begin
        f = fns[$urandom_range(0, 3)];
        w = {f[9:3], w[24:15], f[2:0], 5'd0, 7'h33};
      end
      2: begin
        f = fns[$urandom_range(0, 3)];
        w = {f[9:3], w[24:15], f[2:0], w[11:7], 7'h33};
      end
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    int pulses;
    rst_n = 1'b0; en = 1'b0; mask = 3'd0; valid = 1'b0;
    ready = 1'b0; is_dummy = 1'b0; data = '0; clear = 1'b0;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0013, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0013, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0013, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0033, 1'b1, 1'b0,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h0000_00B3, 1'b1, 1'b0,
                1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h0200_4033, 1'b1, 1'b0,
                1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0013, 1'b1, 1'b0,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h0000_00B3, 1'b1, 1'b0,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'h0200_0033, 1'b0, 1'b0,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h0000_7033, 1'b0, 1'b1,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};

    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 3'd0, 1'b0, 1'b0, "rst");
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 3'd0, 1'b0, 1'b0, "rst");
    chk("reset_real_retire", 32'(real_ret), 32'd0);
    chk("reset_dummy_retire", 32'(dummy_ret), 32'd0);
    chk("reset_alerts", {29'd0, a_mal, a_starve, a_spur}, 32'd0);
    chk("reset_cnt", 32'(cnt), 32'd0);

    foreach (tbl[i]) begin
      step(1'b1, tbl[i].v, tbl[i].rdy, tbl[i].dm, tbl[i].data,
           tbl[i].en, 3'd0, tbl[i].clr, 1'b0, "tbl");
      chk($sformatf("tbl%0d_real", i), 32'(real_ret), 32'(tbl[i].e_rr));
      chk($sformatf("tbl%0d_dummy", i), 32'(dummy_ret), 32'(tbl[i].e_dr));
      chk($sformatf("tbl%0d_mal", i), 32'(a_mal), 32'(tbl[i].e_mal));
      chk($sformatf("tbl%0d_starve", i), 32'(a_starve), 32'(tbl[i].e_st));
      chk($sformatf("tbl%0d_spur", i), 32'(a_spur), 32'(tbl[i].e_sp));
      chk($sformatf("tbl%0d_cnt", i), 32'(cnt), 32'(tbl[i].e_cnt));
    end

    // 3 real + 1 dummy, four times, mask 0
    pulses = 0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++)
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0013, 1'b1, 3'd0, 1'b0, 1'b1, "seqa");
      step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0033, 1'b1, 3'd0, 1'b0, 1'b1, "seqa");
      if (dummy_ret) pulses++;
    end
    chk("seqa_pulses", 32'(pulses), 32'd4);
    chk("seqa_cnt", 32'(cnt), 32'd4);
    chk("seqa_alerts", {29'd0, a_mal, a_starve, a_spur}, 32'd0);

    // four reals sit on the slack edge; stall must not move the gap
    for (int k = 0; k < 4; k++)
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0013, 1'b1, 3'd0, 1'b0, 1'b1, "seqb");
    chk("starve_after_4", 32'(a_starve), 32'd0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 1'b1, 3'd0, 1'b0, 1'b1, "stall");
      pulses += int'(real_ret) + int'(dummy_ret);
    end
    chk("stall_pulses", 32'(pulses), 32'd0);
    chk("stall_starve", 32'(a_starve), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0013, 1'b1, 3'd0, 1'b0, 1'b1, "rel");
    chk("release_pulse", 32'(real_ret), 32'd1);
    chk("starve_after_5", 32'(a_starve), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3'd0, 1'b0, 1'b1, "rel2");
    chk("release_single_pulse", 32'(real_ret), 32'd0);

    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3'd7, 1'b1, 1'b1, "clr");
    for (int k = 0; k < 70000; k++)
      step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0033, 1'b1, 3'd7, 1'b0,
           (k % 1000) == 0, "sat");
    chk("sat_cnt", 32'(cnt), 32'h0000_FFFF);
    chk("sat_pulse", 32'(dummy_ret), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_00B3, 1'b0, 3'd7, 1'b0, 1'b1, "midrst");
    chk("midrst_cnt", 32'(cnt), 32'd0);
    chk("midrst_pulses", {30'd0, real_ret, dummy_ret}, 32'd0);
    chk("midrst_alerts", {29'd0, a_mal, a_starve, a_spur}, 32'd0);

    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) < 2,
           rand_word(),
           $urandom_range(0, 19) != 0,
           3'($urandom_range(0, 7)),
           $urandom_range(0, 99) < 2,
           1'b1, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
